// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - state encodings and default qualification length for debounce_fsm
package debounce_pkg;

  // Legacy-compatible 2-bit state encodings; bit 1 doubles as the debounced level.
  typedef logic [1:0] state_t;

  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] WAIT0 = 2'b11;

  // Number of consecutive cycles a new switch value must hold before it is accepted.
  localparam int DEFAULT_STABLE_CYCLES = 500000;

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronizer for the raw switch input
module debounce_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Shift the asynchronous input through two stages.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Both stages clear to 0 so the FSM never sees a spurious high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - switch debouncer: four-state FSM with down-counter; DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sw_s;

`ifdef DEBOUNCE_SYNC_EN
  debounce_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );
`else
  // Source is already synchronous to clk; feed it straight to the FSM.
  assign sw_s = sw;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state, counter and tick logic; a single old-value sample in WAITx aborts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

  // State, counter and registered tick outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Moore decode: the level is high while accepted-high, including while qualifying a release.
  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;

endmodule
